// File: rtl/int_pkg.sv
// rtl/int_pkg.sv - shared source ids, default vectors and flag encoders for the interrupt controller
package int_pkg;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC1     = 2'd1;
  localparam logic [1:0] SRC2     = 2'd2;
  localparam logic [1:0] SRC3     = 2'd3;

  localparam logic [31:0] DEF_VEC1 = 32'h0000_0100;
  localparam logic [31:0] DEF_VEC2 = 32'h0000_0200;
  localparam logic [31:0] DEF_VEC3 = 32'h0000_0300;

  // Highest set flag wins; bit 0 is source 1, bit 2 is source 3.
  function automatic logic [1:0] prio_enc(input logic [2:0] flags);
    if (flags[2]) return SRC3;
    else if (flags[1]) return SRC2;
    else if (flags[0]) return SRC1;
    else return SRC_NONE;
  endfunction

  // One-hot flag position for a source id; SRC_NONE maps to no bit.
  function automatic logic [2:0] src_mask(input logic [1:0] id);
    case (id)
      SRC1:    return 3'b001;
      SRC2:    return 3'b010;
      SRC3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - two-flop synchroniser with rising-edge pulse for one request line
module edge_sync (
  input  logic clk,
  input  logic RST,
  input  logic din,
  output logic rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // Two metastability stages, then a delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (RST) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= din;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign rise = r_s2 & ~r_s3;

endmodule

// File: rtl/multi_int_ctrl.sv
// rtl/multi_int_ctrl.sv - three-source fixed-priority nesting interrupt controller
module multi_int_ctrl
  import int_pkg::*;
#(
  parameter logic [31:0] VEC1 = DEF_VEC1,
  parameter logic [31:0] VEC2 = DEF_VEC2,
  parameter logic [31:0] VEC3 = DEF_VEC3
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        break1,
  input  logic        break2,
  input  logic        break3,
  input  logic        int_en,
  input  logic        int_ack,
  input  logic        eret,
  output logic        interrupt,
  output logic [1:0]  int_id,
  output logic [31:0] int_pc,
  output logic        IW1,
  output logic        IW2,
  output logic        IW3,
  output logic        ir1_sig,
  output logic        ir2_sig,
  output logic        ir3_sig
);

  logic [2:0]  w_rise;
  logic [2:0]  r_iw;
  logic [2:0]  r_ir;
  logic [1:0]  r_id;
  logic [31:0] r_pc;

  logic [1:0]  w_pend_top;
  logic [1:0]  w_srv_top;
  logic        w_ack;
  logic        w_eret;
  logic [2:0]  w_ack_mask;
  logic [2:0]  w_eret_mask;
  logic [2:0]  w_iw_next;
  logic [2:0]  w_ir_next;
  logic [1:0]  w_id_next;

  edge_sync u_sync1 (.clk(clk), .RST(RST), .din(break1), .rise(w_rise[0]));
  edge_sync u_sync2 (.clk(clk), .RST(RST), .din(break2), .rise(w_rise[1]));
  edge_sync u_sync3 (.clk(clk), .RST(RST), .din(break3), .rise(w_rise[2]));

  function automatic logic [31:0] vec_of(input logic [1:0] id);
    case (id)
      SRC1:    return VEC1;
      SRC2:    return VEC2;
      SRC3:    return VEC3;
      default: return 32'h0000_0000;
    endcase
  endfunction

  assign w_pend_top = prio_enc(r_iw);
  assign w_srv_top  = prio_enc(r_ir);
  assign interrupt  = int_en & (w_pend_top > w_srv_top);

  // Ack and eret both act on pre-edge state; the acked bit is applied after the eret clear
  // so a combined ack+eret leaves the new handler in service, and a fresh edge beats an ack clear.
  always_comb begin
    w_ack       = int_ack & interrupt;
    w_eret      = eret & (w_srv_top != SRC_NONE);
    w_ack_mask  = w_ack  ? src_mask(w_pend_top) : 3'b000;
    w_eret_mask = w_eret ? src_mask(w_srv_top)  : 3'b000;
    w_iw_next   = (r_iw & ~w_ack_mask) | w_rise;
    w_ir_next   = (r_ir & ~w_eret_mask) | w_ack_mask;
    w_id_next   = r_id;
    if (w_ack) begin
      w_id_next = w_pend_top;
    end else if (w_eret) begin
      w_id_next = prio_enc(w_ir_next);
    end
  end

  // Pending, in-service and current-handler registers
  always_ff @(posedge clk) begin
    if (RST) begin
      r_iw <= 3'b000;
      r_ir <= 3'b000;
      r_id <= SRC_NONE;
      r_pc <= 32'h0000_0000;
    end else begin
      r_iw <= w_iw_next;
      r_ir <= w_ir_next;
      r_id <= w_id_next;
      r_pc <= vec_of(w_id_next);
    end
  end

  assign int_id  = r_id;
  assign int_pc  = r_pc;
  assign IW1     = r_iw[0];
  assign IW2     = r_iw[1];
  assign IW3     = r_iw[2];
  assign ir1_sig = r_ir[0];
  assign ir2_sig = r_ir[1];
  assign ir3_sig = r_ir[2];

endmodule

// File: tb/tb_multi_int_ctrl.sv
// tb/tb_multi_int_ctrl.sv - self-checking bench for multi_int_ctrl against a behavioural model
module tb_multi_int_ctrl;

  logic        clk = 1'b0;
  logic        RST, break1, break2, break3, int_en, int_ack, eret;
  logic        interrupt;
  logic [1:0]  int_id;
  logic [31:0] int_pc;
  logic        IW1, IW2, IW3, ir1_sig, ir2_sig, ir3_sig;

  int total = 0;
  int bad   = 0;

  multi_int_ctrl dut (
    .clk(clk), .RST(RST), .break1(break1), .break2(break2), .break3(break3),
    .int_en(int_en), .int_ack(int_ack), .eret(eret), .interrupt(interrupt),
    .int_id(int_id), .int_pc(int_pc), .IW1(IW1), .IW2(IW2), .IW3(IW3),
    .ir1_sig(ir1_sig), .ir2_sig(ir2_sig), .ir3_sig(ir3_sig)
  );

  always #5 clk = ~clk;

  // Reference model: sampled break history per clock edge, pending/in-service sets
  bit [3:1]    samp [0:8191];
  int          cyc = 3;
  bit [3:1]    m_iw = '0;
  bit [3:1]    m_ir = '0;
  int          m_id = 0;
  logic [31:0] m_pc = '0;

  function automatic int top3(input bit [3:1] f);
    for (int n = 3; n >= 1; n--) if (f[n]) return n;
    return 0;
  endfunction

  function automatic logic [31:0] vec(input int id);
    case (id)
      1: return 32'h0000_0100;
      2: return 32'h0000_0200;
      3: return 32'h0000_0300;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    bit [3:1] ev;
    int pt, st;
    bit take;
    samp[cyc] = {break3, break2, break1};
    if (RST) begin
      m_iw = '0; m_ir = '0; m_id = 0; m_pc = '0;
      samp[cyc] = '0; samp[cyc-1] = '0; samp[cyc-2] = '0;
    end else begin
      // A line sampled high two edges ago after being low three edges ago is a new request now
      ev   = samp[cyc-2] & ~samp[cyc-3];
      pt   = top3(m_iw);
      st   = top3(m_ir);
      take = int_ack && int_en && (pt > st);
      if (take) m_iw[pt] = 1'b0;
      if (eret && st > 0) m_ir[st] = 1'b0;
      if (take) m_ir[pt] = 1'b1;
      m_iw = m_iw | ev;
      if (take) m_id = pt;
      else if (eret && st > 0) m_id = top3(m_ir);
      m_pc = vec(m_id);
    end
    cyc++;
  endtask

  function automatic logic [40:0] exp_vec();
    logic e_int;
    e_int = int_en && (top3(m_iw) > top3(m_ir));
    return {e_int, 2'(m_id), m_pc, m_iw, m_ir};
  endfunction

  function automatic logic [40:0] obs_vec();
    return {interrupt, int_id, int_pc, IW3, IW2, IW1, ir3_sig, ir2_sig, ir1_sig};
  endfunction

  // {RST, b3, b2, b1, ack, eret, en}
  task automatic drive(input logic [6:0] v);
    {RST, break3, break2, break1, int_ack, eret, int_en} = v;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] seq [$] = '{7'b1_000_000, 7'b1_001_000, 7'b1_001_000, 7'b1_000_000, 7'b1_000_000};
    foreach (seq[i]) begin
      drive(seq[i]); tick();
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL reset_hold step=%0d got=%h exp=%h", i, obs_vec(), exp_vec()); end
    end
    drive(7'b0_000_001);
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (obs_vec() !== 41'd0) begin bad++; $display("FAIL reset_idle step=%0d got=%h exp=0", i, obs_vec()); end
    end
  endtask

  task automatic test_single();
    logic [6:0] seq [$] = '{7'b0_001_001, 7'b0_000_001, 7'b0_000_001, 7'b0_000_001, 7'b0_000_001,
                            7'b0_000_101, 7'b0_000_001, 7'b0_000_011, 7'b0_000_001};
    foreach (seq[i]) begin
      drive(seq[i]); tick();
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL single step=%0d got=%h exp=%h", i, obs_vec(), exp_vec()); end
      if (i == 3) begin
        total++;
        if ({IW1, interrupt} !== 2'b11) begin bad++; $display("FAIL single_pend got=%b exp=11", {IW1, interrupt}); end
      end
      if (i == 5) begin
        total++;
        if ({IW1, ir1_sig, int_id, int_pc} !== {1'b0, 1'b1, 2'd1, 32'h100}) begin
          bad++; $display("FAIL single_ack got=%b%b id=%0d pc=%h exp=01 id=1 pc=100", IW1, ir1_sig, int_id, int_pc);
        end
      end
      if (i == 7) begin
        total++;
        if ({ir1_sig, int_id, interrupt} !== 4'b0000) begin bad++; $display("FAIL single_eret got=%b exp=0000", {ir1_sig, int_id, interrupt}); end
      end
    end
  endtask

  task automatic test_nesting();
    logic [6:0] seq [$] = '{7'b0_001_001, 7'b0_000_001, 7'b0_000_001, 7'b0_000_001, 7'b0_000_101,
                            7'b0_100_001, 7'b0_000_001, 7'b0_000_001, 7'b0_000_101, 7'b0_000_011,
                            7'b0_000_011, 7'b0_000_001};
    foreach (seq[i]) begin
      drive(seq[i]); tick();
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL nesting step=%0d got=%h exp=%h", i, obs_vec(), exp_vec()); end
      if (i == 7) begin
        total++;
        if ({ir1_sig, IW3, interrupt} !== 3'b111) begin bad++; $display("FAIL nest_preempt got=%b exp=111", {ir1_sig, IW3, interrupt}); end
      end
      if (i == 8) begin
        total++;
        if ({ir3_sig, ir1_sig, int_pc} !== {2'b11, 32'h300}) begin bad++; $display("FAIL nest_ack got=%b pc=%h exp=11 pc=300", {ir3_sig, ir1_sig}, int_pc); end
      end
      if (i == 9) begin
        total++;
        if ({ir3_sig, ir1_sig, int_id, int_pc} !== {2'b01, 2'd1, 32'h100}) begin
          bad++; $display("FAIL nest_eret got=%b id=%0d pc=%h exp=01 id=1 pc=100", {ir3_sig, ir1_sig}, int_id, int_pc);
        end
      end
    end
  endtask

  task automatic test_blocking();
    logic [6:0] seq [$] = '{7'b0_100_001, 7'b0_000_001, 7'b0_000_001, 7'b0_000_001, 7'b0_000_101,
                            7'b0_010_001, 7'b0_000_001, 7'b0_000_001, 7'b0_000_001, 7'b0_000_011,
                            7'b0_000_101, 7'b0_000_011, 7'b0_000_001};
    foreach (seq[i]) begin
      drive(seq[i]); tick();
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL blocking step=%0d got=%h exp=%h", i, obs_vec(), exp_vec()); end
      if (i == 8) begin
        total++;
        if ({ir3_sig, IW2, interrupt} !== 3'b110) begin bad++; $display("FAIL block_hold got=%b exp=110", {ir3_sig, IW2, interrupt}); end
      end
      if (i == 9) begin
        total++;
        if ({ir3_sig, interrupt} !== 2'b01) begin bad++; $display("FAIL block_release got=%b exp=01", {ir3_sig, interrupt}); end
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [6:0] seq [$] = '{7'b0_111_000, 7'b0_000_000, 7'b0_000_000, 7'b0_000_000, 7'b0_000_000,
                            7'b0_000_001, 7'b0_000_101, 7'b0_000_011, 7'b0_000_101, 7'b0_000_011,
                            7'b0_000_101, 7'b0_000_011, 7'b0_000_001};
    foreach (seq[i]) begin
      drive(seq[i]); tick();
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL simult step=%0d got=%h exp=%h", i, obs_vec(), exp_vec()); end
      if (i == 4) begin
        total++;
        if ({IW3, IW2, IW1, interrupt} !== 4'b1110) begin bad++; $display("FAIL simult_mask got=%b exp=1110", {IW3, IW2, IW1, interrupt}); end
      end
      if (i == 6 || i == 8 || i == 10) begin
        total++;
        if (int_id !== 2'(3 - (i - 6) / 2)) begin bad++; $display("FAIL simult_order step=%0d got=%0d exp=%0d", i, int_id, 3 - (i - 6) / 2); end
      end
    end
  endtask

  task automatic test_collision();
    logic [6:0] seq [$] = '{7'b0_010_001, 7'b0_000_001, 7'b0_000_001, 7'b0_010_001, 7'b0_000_001,
                            7'b0_000_101, 7'b0_000_101, 7'b0_000_011, 7'b0_000_101, 7'b0_000_011,
                            7'b0_000_001};
    foreach (seq[i]) begin
      drive(seq[i]); tick();
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL collision step=%0d got=%h exp=%h", i, obs_vec(), exp_vec()); end
      if (i == 5 || i == 6) begin
        total++;
        if ({ir2_sig, IW2, int_id, interrupt} !== {2'b11, 2'd2, 1'b0}) begin
          bad++; $display("FAIL collide step=%0d got=%b exp=11100", i, {ir2_sig, IW2, int_id, interrupt});
        end
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] v;
    for (int i = 0; i < 600; i++) begin
      v[6]   = ($urandom_range(0, 99) < 1);
      v[5:3] = 3'($urandom);
      v[5:3] = v[5:3] & 3'($urandom) & 3'($urandom);
      v[2]   = ($urandom_range(0, 99) < 30);
      v[1]   = ($urandom_range(0, 99) < 20);
      v[0]   = ($urandom_range(0, 99) < 80);
      drive(v); tick();
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL random step=%0d in=%b got=%h exp=%h", i, v, obs_vec(), exp_vec()); end
    end
    drive(7'b0_000_001);
  endtask

  initial begin
    drive(7'b1_000_000);
    test_reset();
    test_single();
    test_nesting();
    test_blocking();
    test_simultaneous();
    test_collision();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_int_ctrl.md
# multi_int_ctrl

Three-source prioritised interrupt controller that receives the `break1`–`break3` request lines and delivers them to the CPU core with nesting support. It sits between the external break inputs and the core's interrupt entry/return logic. It synchronises and edge-detects each request and keeps a pending flag (IW) and an in-service flag (ir) per source. It hands the core the highest-priority eligible source and its entry address, and unwinds one nesting level per return-from-interrupt.

## Interface
Parameters:
- `VEC1`, default 32'h0000_0100: entry PC for source 1
- `VEC2`, default 32'h0000_0200: entry PC for source 2
- `VEC3`, default 32'h0000_0300: entry PC for source 3

Ports:
- `clk` in 1: system clock, all state on rising edge
- `RST` in 1: reset, synchronous, active-high
- `break1`, `break2`, `break3` in 1 each: raw request lines, level pulses, may be asynchronous
- `int_en` in 1: global interrupt enable from the core
- `int_ack` in 1: one-cycle pulse, core takes the offered interrupt at an instruction boundary
- `eret` in 1: one-cycle pulse, core returns from the current handler
- `interrupt` out 1: request to core
- `int_id` out 2: source being serviced (1..3, 0 = none)
- `int_pc` out 32: entry PC of `int_id`
- `IW1`, `IW2`, `IW3` out 1 each: pending flags
- `ir1_sig`, `ir2_sig`, `ir3_sig` out 1 each: in-service flags

## Operation
- Priority is fixed: source 3 > 2 > 1.
- Per source: 2-FF synchroniser, then a third register for rising-edge detect. An edge sets that source's IW.
- Level of an IW source = its index. `pend_top` = highest set IW (0 if none). `srv_top` = highest set ir (0 if none).
- `interrupt` = `int_en` & (`pend_top` > `srv_top`). It is combinational from registered state only, never from raw `break*`.
- `int_ack` while `interrupt`=1 updates, at that edge:
  - IW[`pend_top`] ← 0
  - ir[`pend_top`] ← 1
  - `int_id` ← `pend_top`
  - `int_pc` ← VEC[`pend_top`]
- `int_ack` while `interrupt`=0 is ignored; no state change.
- `eret` clears ir[`srv_top`] and sets `int_id`/`int_pc` to the new `srv_top` and its vector (0/0 if none). `eret` with no ir set is ignored.
- Nesting: a higher source preempts a lower in-service one. Equal or lower sources stay pending until `srv_top` drops below them.
- Simultaneous events:
  - A new edge on source n in the same cycle that an ack clears IW[n]: set wins, IW[n] stays 1.
  - `int_ack` and `eret` in the same cycle: ack is evaluated on pre-edge state, eret clears the pre-edge `srv_top`, and the newly acked bit is then set. `int_id`/`int_pc` take the acked source.
  - Two or more edges in the same cycle: all IW set, serviced highest first.
- A repeated edge on an already-pending source is absorbed; there is no counting.
- `int_en`=0 masks `interrupt` only. IW and ir keep updating.

## Timing
- Reset: all synchroniser stages, IW*, ir*, `int_id`, `int_pc` = 0, so `interrupt` = 0. `RST` mid-operation discards all pending and in-service state at that edge.
- Request latency: `break*` sampled high at edge k gives IW high after edge k+2. `interrupt` follows in the same cycle if eligible.
- Minimum `break*` pulse: one full `clk` period high and one full period low between pulses. Shorter pulses may be lost.
- Ack latency: `int_id`/`int_pc`/ir valid the cycle after the `int_ack` edge. `interrupt` re-evaluates the same cycle.
- `int_ack` and `eret` are edge-sampled single-cycle pulses. A pulse held multiple cycles acts once per cycle.

## Structure
- Shared package (`int_pkg`):
  - source-id constants `SRC_NONE`=0, `SRC1`..`SRC3`
  - priority-encoder function for the 3-bit flag vectors
  - default vector constants
- Sub-module `edge_sync`: 2-FF synchroniser plus rising-edge pulse. Ports `clk`, `RST`, `din`, `rise`. Instantiated three times.
- Top level holds the IW/ir registers, the compare logic and the vector mux.

## Test plan
- Reset then idle: all outputs 0 for 20 cycles. A `break1` pulse while `RST`=1 leaves IW1=0.
- Single request: `break1` high for 1 cycle at edge 10 → IW1=1 after edge 12, `interrupt`=1. `int_ack` at edge 15 → IW1=0, ir1_sig=1, `int_id`=1, `int_pc`=32'h100. `eret` → ir1_sig=0, `int_id`=0.
- Nesting: service source 1, then `break3` → `interrupt`=1. Ack → ir3_sig=1, ir1_sig=1, `int_pc`=32'h300. `eret` clears ir3 only, `int_id`=1, `int_pc`=32'h100.
- Blocking: service source 3, then `break2` → IW2=1, `interrupt`=0 until `eret`, then `interrupt`=1.
- Simultaneous: `break1`/`break2`/`break3` on the same edge → acks deliver ids 3, then 2 (after eret), then 1. `int_en`=0 holds `interrupt`=0 with IW1..3=1.
- Collision: a new `break2` edge lands in the ack cycle of source 2 → ir2_sig=1 and IW2 remains 1. `int_ack` with `interrupt`=0 changes nothing.
